// File: rtl/ftdi_pkg.sv
// ftdi_pkg: state encoding, byte-enable constants and width check shared by the FT60x write master
package ftdi_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_WAIT, ST_GAP} ftdi_state_e;
  localparam logic [3:0] FT_BE_ALL32 = 4'hF;
  localparam logic [1:0] FT_BE_ALL16 = 2'h3;
  localparam int FT_W16 = 16;
  localparam int FT_W32 = 32;
  function automatic bit ft_width_ok(input int w);
    return w == FT_W16 || w == FT_W32;
  endfunction
endpackage

// File: rtl/ftdi_out_reg.sv
// ftdi_out_reg: single-word holding register with upstream ready and bus transfer detection
module ftdi_out_reg #(
  parameter int DATA_W = 32,
  parameter int BE_W = DATA_W / 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] s_data_in,
  input  logic [BE_W-1:0]   s_be_in,
  input  logic              s_last_in,
  input  logic              s_valid_in,
  input  logic              hold_in,
  input  logic              wr_n_in,
  input  logic              txe_n_in,
  output logic              s_ready_out,
  output logic              xfer_out,
  output logic [DATA_W-1:0] data_out,
  output logic [BE_W-1:0]   be_out,
  output logic              last_out,
  output logic              ov_out
);
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0] be_q;
  logic last_q, ov_q, load;
  assign xfer_out = !wr_n_in && !txe_n_in;
  assign s_ready_out = !hold_in && (!ov_q || xfer_out);
  assign load = s_valid_in && s_ready_out;
  assign data_out = data_q;
  assign be_out = be_q;
  assign last_out = last_q;
  assign ov_out = ov_q;
  // hold the word until the bus takes it; a same-cycle load replaces the one just sent
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_q <= '0;
      be_q <= '0;
      last_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      if (load) begin
        data_q <= s_data_in;
        be_q <= s_be_in;
        last_q <= s_last_in;
      end
      ov_q <= load ? 1'b1 : xfer_out ? 1'b0 : ov_q;
    end
  end
endmodule

// File: rtl/ftdi_write_master.sv
// ftdi_write_master: FT60x write-side burst sequencer; define FTDI_WR_STATS_EN to add transfer and stall counters
module ftdi_write_master
  import ftdi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 1024,
  parameter int GAP_CYC = 2,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] s_data_in,
  input  logic [BE_W-1:0]   s_be_in,
  input  logic              s_last_in,
  input  logic              s_valid_in,
  output logic              s_ready_out,
  input  logic              txe_n_in,
  output logic [DATA_W-1:0] data_out,
  output logic [BE_W-1:0]   be_out,
  output logic              wr_n_out,
  output logic              data_oe_out,
  output logic [15:0]       burst_len_out
`ifdef FTDI_WR_STATS_EN
  ,
  output logic [31:0]       stat_words_out,
  output logic [31:0]       stat_stall_out
`endif
);
  localparam logic [15:0] MAX_L = 16'(MAX_BURST);
  localparam logic [3:0] GAP_L = 4'(GAP_CYC - 1);
  if (!ft_width_ok(DATA_W) || MAX_BURST < 1 || MAX_BURST > 65535 || GAP_CYC < 1 || GAP_CYC > 15) begin : g_bad_param
    $error("ftdi_write_master: illegal parameter value");
  end
  ftdi_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] gcnt_q, gcnt_d;
  logic ov, last, xfer, load;
  ftdi_out_reg #(.DATA_W(DATA_W), .BE_W(BE_W)) u_out (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .s_data_in(s_data_in),
    .s_be_in(s_be_in),
    .s_last_in(s_last_in),
    .s_valid_in(s_valid_in),
    .hold_in(state_q == ST_GAP),
    .wr_n_in(wr_n_out),
    .txe_n_in(txe_n_in),
    .s_ready_out(s_ready_out),
    .xfer_out(xfer),
    .data_out(data_out),
    .be_out(be_out),
    .last_out(last),
    .ov_out(ov)
  );
  assign load = s_valid_in && s_ready_out;
  assign wr_n_out = !(state_q == ST_BURST && ov);
  assign data_oe_out = state_q != ST_IDLE;
  assign burst_len_out = cnt_q;
  assign cnt_inc = cnt_q == MAX_L ? cnt_q : cnt_q + 16'd1;
  // next state: burst sequencing, saturating word counter and gap timer
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gcnt_d = gcnt_q;
    case (state_q)
      ST_IDLE: if (ov && !txe_n_in) begin
        state_d = ST_BURST;
        cnt_d = '0;
      end
      ST_BURST: if (xfer) begin
        cnt_d = cnt_inc;
        if (last || cnt_inc == MAX_L) begin
          state_d = ST_GAP;
          gcnt_d = '0;
        end
      end else if (ov) state_d = ST_WAIT;
      else if (!load) state_d = ST_IDLE;
      ST_WAIT: if (!txe_n_in) state_d = ST_BURST;
      ST_GAP: if (gcnt_q == GAP_L) begin
        // the gap's last cycle doubles as the IDLE decision so the high time is exactly GAP_CYC
        state_d = ov && !txe_n_in ? ST_BURST : ST_IDLE;
        cnt_d = ov && !txe_n_in ? '0 : cnt_q;
      end else gcnt_d = gcnt_q + 4'd1;
      default: state_d = ST_IDLE;
    endcase
  end
  // state, counter and gap timer registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gcnt_q <= gcnt_d;
    end
  end
`ifdef FTDI_WR_STATS_EN
  logic [31:0] words_q, stall_q;
  assign stat_words_out = words_q;
  assign stat_stall_out = stall_q;
  // free-running transfer and WAIT-cycle counters, wrapping modulo 2^32
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_q + {31'd0, xfer};
      stall_q <= stall_q + {31'd0, state_q == ST_WAIT};
    end
  end
`endif
endmodule
